// File: rtl/abc_pkg.sv
// Shared types and default sizing for the multi-channel ABC coincidence counter.
package abc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    HOLD = 2'd2
  } abc_state_e;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 8;
  localparam int WW_DEF  = 4;
  localparam int GW_DEF  = 16;

endpackage

// File: rtl/abc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module abc_sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);

  logic [CW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      if (clr) begin
        r_q <= '0;
      end else if (inc && (r_q != {CW{1'b1}})) begin
        r_q <= r_q + 1'b1;
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/abc_multi_coinc.sv
// Multi-channel singles and trigger-coincidence counter over a gated acquisition.
// Channel 0 opens a window; each other channel may score once per window.
module abc_multi_coinc
  import abc_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF,
  parameter int WW  = WW_DEF,
  parameter int GW  = GW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NCH-1:0]       x,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WW-1:0]        win_len,
  input  logic [GW-1:0]        gate_len,
  output logic [NCH*CW-1:0]    singles,
  output logic [(NCH-1)*CW-1:0] coinc,
  output logic                 busy,
  output logic                 done,
  output abc_state_e           state
);

  logic [NCH-1:0] r_s1, r_s2, r_prev;
  logic [NCH-1:0] w_edge;
  abc_state_e     r_state, w_state_nxt;
  logic           r_busy, r_done;
  logic [GW-1:0]  r_gate_rem;
  logic [WW-1:0]  r_win_rem;
  logic [NCH-2:0] r_armed;
  logic           w_acq;
  logic           w_win_open;
  logic [NCH-2:0] w_hit;

  assign w_edge     = r_s2 & ~r_prev;
  assign w_acq      = (r_state == ACQ);
  assign w_win_open = w_edge[0] | (r_win_rem != '0);
  // A trigger in the same cycle counts as arming the channel for this window.
  assign w_hit      = w_edge[NCH-1:1] & {(NCH-1){w_win_open}}
                    & (r_armed | {(NCH-1){w_edge[0]}});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = ACQ;
      ACQ: begin
        if (start)                                 w_state_nxt = ACQ;
        else if (stop || (r_gate_rem == GW'(1)))   w_state_nxt = HOLD;
      end
      HOLD: if (start) w_state_nxt = ACQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_prev     <= '0;
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gate_rem <= '0;
      r_win_rem  <= '0;
      r_armed    <= '0;
    end else if (enable) begin
      r_s1    <= x;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ACQ);
      r_done  <= (w_state_nxt == HOLD);
      // A zero gate never decrements, so ACQ runs until stop.
      if (start) begin
        r_gate_rem <= gate_len;
      end else if (w_acq && (r_gate_rem != '0)) begin
        r_gate_rem <= r_gate_rem - 1'b1;
      end
      if (start) begin
        r_win_rem <= '0;
        r_armed   <= '0;
      end else begin
        if (w_edge[0]) begin
          r_win_rem <= win_len;
        end else if (r_win_rem != '0) begin
          r_win_rem <= r_win_rem - 1'b1;
        end
        r_armed <= (w_edge[0] ? {(NCH-1){1'b1}} : r_armed) & ~w_hit;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_singles
    abc_sat_counter #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enable),
      .clr   (start),
      .inc   (w_acq & w_edge[i]),
      .q     (singles[i*CW +: CW])
    );
  end

  for (genvar j = 0; j < NCH-1; j++) begin : g_coinc
    abc_sat_counter #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enable),
      .clr   (start),
      .inc   (w_acq & w_hit[j]),
      .q     (coinc[j*CW +: CW])
    );
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: tb/tb_abc_multi_coinc.sv
// Directed bench for abc_multi_coinc: window table plus hand-written control sequences.
module tb_abc_multi_coinc;
  import abc_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int WW  = 4;
  localparam int GW  = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic [NCH-1:0]        x;
  logic                  start;
  logic                  stop;
  logic [WW-1:0]         win_len;
  logic [GW-1:0]         gate_len;
  logic [NCH*CW-1:0]     singles;
  logic [(NCH-1)*CW-1:0] coinc;
  logic                  busy;
  logic                  done;
  abc_state_e            state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          trig_at;
    int          ch_at;
    int          ch;
    logic [3:0]  win;
    int          exp_c;
  } vec_t;

  vec_t           vecs[6];
  logic [NCH-1:0] pat[16];

  abc_multi_coinc #(.NCH(NCH), .CW(CW), .WW(WW), .GW(GW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .x        (x),
    .start    (start),
    .stop     (stop),
    .win_len  (win_len),
    .gate_len (gate_len),
    .singles  (singles),
    .coinc    (coinc),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] s_of(input int i);
    return singles[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] c_of(input int j);
    return coinc[j*CW +: CW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [GW-1:0] g);
    @(negedge clk);
    gate_len = g;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_pat();
    for (int c = 0; c < 16; c++) pat[c] = '0;
  endtask

  task automatic play(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      x = pat[c];
    end
    @(negedge clk);
    x = '0;
  endtask

  initial begin
    int n;
    int c;
    rst_n = 1'b0; enable = 1'b1; x = '0; start = 1'b0; stop = 1'b0;
    win_len = '0; gate_len = '0;

    // reset with activity on the inputs
    repeat (2) begin
      @(negedge clk);
      x = ~x;
    end
    check("rst_singles", {16'd0, singles}, 32'd0);
    check("rst_coinc", {20'd0, coinc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));

    @(negedge clk);
    rst_n = 1'b1;
    x = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      x = k[0] ? 4'b0000 : 4'b1111;
    end
    x = '0;
    idle(5);
    check("idle_singles", {16'd0, singles}, 32'd0);
    check("idle_state", 32'(state), 32'(IDLE));

    // gate of 100 cycles with 5 pulses on channel 1
    do_start(16'd100);
    check("start_busy", {31'd0, busy}, 32'd1);
    n = 0; c = 0;
    while (busy && c < 300) begin
      n++;
      x = (c > 0 && c % 5 == 0 && c <= 25) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      c++;
    end
    x = '0;
    check("gate_busy_cycles", n, 100);
    check("gate_done", {31'd0, done}, 32'd1);
    check("gate_state", 32'(state), 32'(HOLD));
    check("gate_singles1", s_of(1), 5);
    clear_pat();
    pat[0] = 4'b0010;
    play(1);
    idle(6);
    check("hold_frozen", s_of(1), 5);

    // window table: trigger cycle, channel cycle, channel, window, expected coinc
    vecs[0] = '{trig_at: 0, ch_at: 3, ch: 1, win: 4'd3, exp_c: 1};
    vecs[1] = '{trig_at: 0, ch_at: 4, ch: 1, win: 4'd3, exp_c: 0};
    vecs[2] = '{trig_at: 0, ch_at: 0, ch: 2, win: 4'd3, exp_c: 1};
    vecs[3] = '{trig_at: 0, ch_at: 0, ch: 3, win: 4'd0, exp_c: 1};
    vecs[4] = '{trig_at: 0, ch_at: 1, ch: 1, win: 4'd0, exp_c: 0};
    vecs[5] = '{trig_at: 3, ch_at: 0, ch: 2, win: 4'd5, exp_c: 0};
    for (int v = 0; v < 6; v++) begin
      win_len = vecs[v].win;
      do_start(16'd0);
      idle(3);
      clear_pat();
      pat[vecs[v].trig_at][0] = 1'b1;
      pat[vecs[v].ch_at][vecs[v].ch] = 1'b1;
      play((vecs[v].trig_at > vecs[v].ch_at ? vecs[v].trig_at : vecs[v].ch_at) + 1);
      idle(8);
      check($sformatf("vec%0d_coinc", v), c_of(vecs[v].ch - 1), vecs[v].exp_c);
      check($sformatf("vec%0d_singles", v), s_of(vecs[v].ch), 1);
      do_stop();
    end

    // two channel-1 edges inside one window score once
    win_len = 4'd8;
    do_start(16'd0);
    idle(3);
    clear_pat();
    pat[0] = 4'b0001; pat[2] = 4'b0010; pat[5] = 4'b0010;
    play(6);
    idle(8);
    check("arm_coinc0", c_of(0), 1);
    check("arm_singles1", s_of(1), 2);

    // retrigger inside the window re-arms channel 1
    win_len = 4'd3;
    do_start(16'd0);
    idle(3);
    clear_pat();
    pat[0] = 4'b0001; pat[2] = 4'b0010; pat[3] = 4'b0001; pat[6] = 4'b0010;
    play(7);
    idle(8);
    check("retrig_coinc0", c_of(0), 2);
    check("retrig_singles0", s_of(0), 2);

    // saturation of a 4-bit counter
    do_start(16'd0);
    idle(3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); x = 4'b0001;
      @(negedge clk); x = 4'b0000;
    end
    idle(6);
    check("sat_singles0", s_of(0), 15);

    // continuous gate ends only on stop
    do_start(16'd0);
    idle(50);
    check("cont_busy", {31'd0, busy}, 32'd1);
    do_stop();
    check("cont_state", 32'(state), 32'(HOLD));
    check("cont_done", {31'd0, done}, 32'd1);
    check("cont_busy_after", {31'd0, busy}, 32'd0);

    // restart while acquiring clears the counters
    do_start(16'd0);
    idle(3);
    clear_pat();
    pat[0] = 4'b0010; pat[2] = 4'b0010; pat[4] = 4'b0010;
    play(5);
    idle(6);
    check("restart_pre", s_of(1), 3);
    do_start(16'd0);
    check("restart_cleared", s_of(1), 0);
    check("restart_busy", {31'd0, busy}, 32'd1);

    // start beats stop in the same cycle
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_state", 32'(state), 32'(ACQ));
    check("startstop_busy", {31'd0, busy}, 32'd1);
    do_stop();

    // enable low for 10 cycles stretches a 30-cycle gate to 40
    do_start(16'd30);
    n = 0; c = 0;
    while (busy && c < 300) begin
      n++;
      enable = !(c >= 10 && c < 20);
      if (c == 3)                        x = 4'b0010;
      else if (c >= 10 && c < 20 && c[0]) x = 4'b0100;
      else                                x = 4'b0000;
      @(negedge clk);
      c++;
    end
    enable = 1'b1;
    x = '0;
    check("en_busy_cycles", n, 40);
    check("en_singles2", s_of(2), 0);
    check("en_singles1", s_of(1), 1);
    check("en_state", 32'(state), 32'(HOLD));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
